nd_1to2: RTL and testbench
==========================

Name: nd_1to2

Overview:
Single-input, two-output message router node with 4-phase req/ack channels on every side. It takes one message per handshake on i0, checks its redundancy field, and forwards it unchanged to o1 when the dst range compare is true, or to o0 when it is false. It sits between a message source channel and two sink channels, and is the device under test placed between the src and snk halves of the 1-to-2 debug harness. Each output has a one-message holding slot, so a message for the idle output is not stalled behind a busy one.

Parameters:
OPER_1, `NS_GT_OP, first compare operator applied to dst.
REF_VAL_1, 0, first compare reference value.
IS_RANGE, `NS_FALSE, when true the route compare is (dst OPER_1 REF_VAL_1) AND (dst OPER_2 REF_VAL_2); when false only the first compare is used.
OPER_2, `NS_GT_OP, second compare operator.
REF_VAL_2, 0, second compare reference value.
ASZ, `NS_ADDRESS_SIZE, width of src and dst.
DSZ, `NS_DATA_SIZE, width of dat.
RSZ, `NS_REDUN_SIZE, width of red.

Ports:
i_clk  in  1  sole clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
i0_src/i0_dst/i0_dat/i0_red  in  ASZ/ASZ/DSZ/RSZ  input message fields.
i0_req  in  1  input request.
i0_ack  out  1  input acknowledge.
o0_src/o0_dst/o0_dat/o0_red  out  ASZ/ASZ/DSZ/RSZ  output-0 message fields (compare false).
o0_req  out  1  output-0 request.
o0_ack  in  1  output-0 acknowledge.
o1_src/o1_dst/o1_dat/o1_red  out  ASZ/ASZ/DSZ/RSZ  output-1 message fields (compare true).
o1_req  out  1  output-1 request.
o1_ack  in  1  output-1 acknowledge.
o_err  out  1  sticky flag for a redundancy mismatch.
o_err_cnt  out  8  count of dropped messages; saturates at 255.

Behaviour:
- Reset: i0_ack, o0_req, o1_req and o_err are 0; o_err_cnt is 0; both slots are empty; all message registers are 0; both FSMs are in IDLE.
- Reset mid-transfer aborts the transfer and discards any held message; peers see req/ack fall.
- All inputs are synchronous to i_clk. There is no internal debouncing.
- RX FSM:
  - RX_IDLE: when i0_req=1 and i0_ack=0, latch the four fields and go to RX_CHK.
  - RX_CHK: calc_redun over the latched src/dst/dat gives the expected red.
    - Mismatch: set o_err, increment o_err_cnt (saturating), drop the message, go to RX_ACK.
    - Otherwise, select the target: o1 if the compare is true, else o0. If the target slot is empty, write the slot, mark it full and go to RX_ACK. If the slot is full, stay in RX_CHK (stall).
  - RX_ACK: drive i0_ack=1. When i0_req=0, drop i0_ack and go to RX_IDLE. The next message cannot be latched until i0_ack has been seen at 0.
- TX FSM, one per output n:
  - TX_IDLE: when slot n is full, set on_req=1 and go to TX_WAIT_HI.
  - TX_WAIT_HI: on_req stays 1 and on_* are stable. When on_ack=1, clear on_req, mark slot n empty and go to TX_WAIT_LO.
  - TX_WAIT_LO: when on_ack=0, go to TX_IDLE.
- on_* fields are driven directly from the slot n registers. A slot may be rewritten while its TX FSM is in TX_WAIT_LO because on_req is 0 then.
- Latency: i0_req first seen in cycle c.
  - Fields latch at the end of c.
  - i0_ack=1 from cycle c+2 onward.
  - on_req=1 from cycle c+3 when the slot was empty.
- Throughput: one message per roughly 4 + upstream/downstream handshake cycles. o0 and o1 transfers may overlap fully.
- Simultaneous events:
  - RX writing slot n while TX n frees it in the same cycle cannot occur; the slot is checked as empty before it is written.
  - Slot 0 and slot 1 activity is independent.
- Field pass-through: src, dst, dat and red are forwarded bit-exact. red is never regenerated.
- Compare: dst is treated as unsigned. The compare semantics are identical to `NS_RANGE_CMP_OP.
- Routing on the forwarded message never changes after latch.

Decomposition:
- Operator codes (`NS_GT_OP etc.), `NS_RANGE_CMP_OP, channel declare/assign macros, `NS_ON/`NS_OFF and the size defaults belong in the shared hglobal.v.
- Reuse the existing calc_redun instance for the check.
- One natural sub-module: nd_tx_slot, containing one holding slot plus its TX FSM, instantiated twice.

Test Plan:
- Use REF_VAL_1=3, GT. Send dst=1..6 with dat=0..5 and valid red. Required: dst 1,2,3 appear on o0 with dat 0,1,2; dst 4,5,6 appear on o1 with dat 3,4,5; o_err=0.
- Hold o1_ack=0 forever. Send dst=5 then dst=2. Required: the dst=2 message completes on o0, and i0_ack for a third dst=6 message never rises.
- Send dst=2 with a corrupted red (xor 1). Required: i0_ack handshake completes, no oN_req, o_err=1, o_err_cnt=1. A following valid message routes normally.
- Use IS_RANGE=true, OPER_1 GT 2, OPER_2 LT 5. Sweep dst 1..6. Required: only dst 3 and 4 go to o1.
- Assert reset one cycle after o0_req rises. Required: o0_req=0 next cycle, slots empty, i0_ack=0, o_err_cnt=0.
- Latency check: with i0_req first seen at cycle c, i0_ack=1 at c+2 and o0_req=1 at c+3.

Source files
------------

// File: rtl/nd_1to2_pkg.sv
// Shared types for the 1-to-2 router node: compare operators, size defaults, FSM states.
// Pure declarations plus the route compare helper; no latency or backpressure of its own.
package nd_1to2_pkg;

  typedef enum logic [2:0] {
    NS_GT_OP  = 3'd0,
    NS_GTE_OP = 3'd1,
    NS_LT_OP  = 3'd2,
    NS_LTE_OP = 3'd3,
    NS_EQ_OP  = 3'd4,
    NS_NE_OP  = 3'd5
  } ns_op_t;

  localparam bit NS_TRUE  = 1'b1;
  localparam bit NS_FALSE = 1'b0;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_CHK, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;

  // Unsigned compare of a zero-extended field against a reference value.
  function automatic logic ns_range_cmp(input ns_op_t op, input logic [31:0] val,
                                        input logic [31:0] ref_val);
    case (op)
      NS_GT_OP:  return val >  ref_val;
      NS_GTE_OP: return val >= ref_val;
      NS_LT_OP:  return val <  ref_val;
      NS_LTE_OP: return val <= ref_val;
      NS_EQ_OP:  return val == ref_val;
      NS_NE_OP:  return val != ref_val;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_redun.sv
// Redundancy code: XOR-fold of {src,dst,dat} into RSZ-bit chunks.
// Purely combinational; no backpressure.
module calc_redun #(
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);

  localparam int MSZ = 2*ASZ + DSZ;

  logic [MSZ-1:0] flat;
  assign flat = {src, dst, dat};

  always_comb begin
    red = '0;
    for (int c = 0; c < MSZ; c += RSZ) begin
      red = red ^ RSZ'(flat >> c);
    end
  end

endmodule

// File: rtl/nd_tx_slot.sv
// One-message holding slot plus its 4-phase output FSM; req rises the cycle after the slot fills.
// Slot stays full (writer must wait) until the sink raises ack.
module nd_tx_slot
  import nd_1to2_pkg::*;
#(
  parameter int MSZ = 28
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [MSZ-1:0] wr_msg,
  output logic           full,
  output logic [MSZ-1:0] msg,
  output logic           req,
  input  logic           ack
);

  tx_state_t state;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state <= TX_IDLE;
      full  <= 1'b0;
      msg   <= '0;
      req   <= 1'b0;
    end else begin
      // The writer only writes an empty slot, so it never races the clear below.
      if (wr_en) begin
        msg  <= wr_msg;
        full <= 1'b1;
      end
      case (state)
        TX_IDLE: begin
          if (full) begin
            req   <= 1'b1;
            state <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (ack) begin
            req   <= 1'b0;
            full  <= 1'b0;
            state <= TX_WAIT_LO;
          end
        end
        TX_WAIT_LO: begin
          if (!ack) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nd_1to2.sv
// 1-in/2-out router: checks redundancy, routes by dst compare; i0_ack 2 cycles and oN_req 3 cycles after req.
// Stalls in the check state while the target slot is full; the other output keeps flowing.
module nd_1to2
  import nd_1to2_pkg::*;
#(
  parameter ns_op_t OPER_1    = NS_GT_OP,
  parameter int     REF_VAL_1 = 0,
  parameter bit     IS_RANGE  = NS_FALSE,
  parameter ns_op_t OPER_2    = NS_GT_OP,
  parameter int     REF_VAL_2 = 0,
  parameter int     ASZ       = NS_ADDRESS_SIZE,
  parameter int     DSZ       = NS_DATA_SIZE,
  parameter int     RSZ       = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o1_src,
  output logic [ASZ-1:0] o1_dst,
  output logic [DSZ-1:0] o1_dat,
  output logic [RSZ-1:0] o1_red,
  output logic           o1_req,
  input  logic           o1_ack,
  output logic           o_err,
  output logic [7:0]     o_err_cnt
);

  localparam int MSZ = 2*ASZ + DSZ + RSZ;

  rx_state_t      rx_state;
  logic [ASZ-1:0] lat_src, lat_dst;
  logic [DSZ-1:0] lat_dat;
  logic [RSZ-1:0] lat_red, exp_red;
  logic           red_ok, route, full0, full1, wr0, wr1;
  logic [MSZ-1:0] lat_msg, slot0_msg, slot1_msg;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun (
    .src (lat_src),
    .dst (lat_dst),
    .dat (lat_dat),
    .red (exp_red)
  );

  assign red_ok  = (exp_red == lat_red);
  assign route   = ns_range_cmp(OPER_1, 32'(lat_dst), 32'(REF_VAL_1)) &&
                   (!IS_RANGE || ns_range_cmp(OPER_2, 32'(lat_dst), 32'(REF_VAL_2)));
  assign lat_msg = {lat_src, lat_dst, lat_dat, lat_red};
  assign wr0     = (rx_state == RX_CHK) && red_ok && !route && !full0;
  assign wr1     = (rx_state == RX_CHK) && red_ok &&  route && !full1;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      lat_src   <= '0;
      lat_dst   <= '0;
      lat_dat   <= '0;
      lat_red   <= '0;
      i0_ack    <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (i0_req && !i0_ack) begin
            lat_src  <= i0_src;
            lat_dst  <= i0_dst;
            lat_dat  <= i0_dat;
            lat_red  <= i0_red;
            rx_state <= RX_CHK;
          end
        end
        RX_CHK: begin
          // A corrupted message is still acknowledged so the source is not wedged.
          if (!red_ok) begin
            o_err <= 1'b1;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            i0_ack   <= 1'b1;
            rx_state <= RX_ACK;
          end else if (wr0 || wr1) begin
            i0_ack   <= 1'b1;
            rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!i0_req) begin
            i0_ack   <= 1'b0;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  nd_tx_slot #(.MSZ(MSZ)) u_slot0 (
    .i_clk  (i_clk),
    .reset  (reset),
    .wr_en  (wr0),
    .wr_msg (lat_msg),
    .full   (full0),
    .msg    (slot0_msg),
    .req    (o0_req),
    .ack    (o0_ack)
  );

  nd_tx_slot #(.MSZ(MSZ)) u_slot1 (
    .i_clk  (i_clk),
    .reset  (reset),
    .wr_en  (wr1),
    .wr_msg (lat_msg),
    .full   (full1),
    .msg    (slot1_msg),
    .req    (o1_req),
    .ack    (o1_ack)
  );

  assign {o0_src, o0_dst, o0_dat, o0_red} = slot0_msg;
  assign {o1_src, o1_dst, o1_dat, o1_red} = slot1_msg;

endmodule

// File: tb/tb_nd_1to2.sv
// Directed bench for nd_1to2: a single-compare instance (dst > 3) and a range instance (2 < dst < 5).
module tb_nd_1to2;
  import nd_1to2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic       reset, req, ack0, ack1;
  logic [7:0] src, dst, dat;
  logic [3:0] red;

  logic       req_w [2];
  logic       i0_ack [2], o0_req [2], o1_req [2], o_err [2];
  logic [7:0] o0_src [2], o0_dst [2], o0_dat [2], o1_src [2], o1_dst [2], o1_dat [2];
  logic [3:0] o0_red [2], o1_red [2];
  logic [7:0] err_cnt [2];

  assign req_w[0] = req && (sel == 0);
  assign req_w[1] = req && (sel == 1);

  nd_1to2 #(
    .OPER_1(NS_GT_OP), .REF_VAL_1(3), .IS_RANGE(NS_FALSE),
    .OPER_2(NS_GT_OP), .REF_VAL_2(0), .ASZ(8), .DSZ(8), .RSZ(4)
  ) dut0 (
    .i_clk(clk), .reset(reset),
    .i0_src(src), .i0_dst(dst), .i0_dat(dat), .i0_red(red),
    .i0_req(req_w[0]), .i0_ack(i0_ack[0]),
    .o0_src(o0_src[0]), .o0_dst(o0_dst[0]), .o0_dat(o0_dat[0]), .o0_red(o0_red[0]),
    .o0_req(o0_req[0]), .o0_ack(ack0),
    .o1_src(o1_src[0]), .o1_dst(o1_dst[0]), .o1_dat(o1_dat[0]), .o1_red(o1_red[0]),
    .o1_req(o1_req[0]), .o1_ack(ack1),
    .o_err(o_err[0]), .o_err_cnt(err_cnt[0])
  );

  nd_1to2 #(
    .OPER_1(NS_GT_OP), .REF_VAL_1(2), .IS_RANGE(NS_TRUE),
    .OPER_2(NS_LT_OP), .REF_VAL_2(5), .ASZ(8), .DSZ(8), .RSZ(4)
  ) dut1 (
    .i_clk(clk), .reset(reset),
    .i0_src(src), .i0_dst(dst), .i0_dat(dat), .i0_red(red),
    .i0_req(req_w[1]), .i0_ack(i0_ack[1]),
    .o0_src(o0_src[1]), .o0_dst(o0_dst[1]), .o0_dat(o0_dat[1]), .o0_red(o0_red[1]),
    .o0_req(o0_req[1]), .o0_ack(ack0),
    .o1_src(o1_src[1]), .o1_dst(o1_dst[1]), .o1_dat(o1_dat[1]), .o1_red(o1_red[1]),
    .o1_req(o1_req[1]), .o1_ack(ack1),
    .o_err(o_err[1]), .o_err_cnt(err_cnt[1])
  );

  function automatic logic [3:0] redf(input logic [7:0] s, input logic [7:0] d, input logic [7:0] t);
    return s[7:4] ^ s[3:0] ^ d[7:4] ^ d[3:0] ^ t[7:4] ^ t[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic port_req(input int port);
    return (port == 1) ? o1_req[sel] : o0_req[sel];
  endfunction

  task automatic put(input logic [7:0] d, input logic [7:0] t, input logic [3:0] corrupt);
    int n = 0;
    src = 8'h50 ^ t;
    dst = d;
    dat = t;
    red = redf(8'h50 ^ t, d, t) ^ corrupt;
    req = 1'b1;
    while (!i0_ack[sel] && n < 20) begin tick(); n++; end
    chk("put_ack_hi", 32'(i0_ack[sel]), 32'd1);
    req = 1'b0;
    n = 0;
    while (i0_ack[sel] && n < 20) begin tick(); n++; end
    chk("put_ack_lo", 32'(i0_ack[sel]), 32'd0);
  endtask

  task automatic get(input int port, input logic [7:0] d, input logic [7:0] t);
    int n = 0;
    logic [7:0] s;
    s = 8'h50 ^ t;
    while (!port_req(port) && n < 30) begin tick(); n++; end
    chk($sformatf("route_req_port%0d_dst%0d", port, d), 32'(port_req(port)), 32'd1);
    if (port == 1) begin
      chk("o1_src", 32'(o1_src[sel]), 32'(s));
      chk("o1_dst", 32'(o1_dst[sel]), 32'(d));
      chk("o1_dat", 32'(o1_dat[sel]), 32'(t));
      chk("o1_red", 32'(o1_red[sel]), 32'(redf(s, d, t)));
      ack1 = 1'b1;
    end else begin
      chk("o0_src", 32'(o0_src[sel]), 32'(s));
      chk("o0_dst", 32'(o0_dst[sel]), 32'(d));
      chk("o0_dat", 32'(o0_dat[sel]), 32'(t));
      chk("o0_red", 32'(o0_red[sel]), 32'(redf(s, d, t)));
      ack0 = 1'b1;
    end
    n = 0;
    while (port_req(port) && n < 20) begin tick(); n++; end
    chk("get_req_lo", 32'(port_req(port)), 32'd0);
    ack0 = 1'b0;
    ack1 = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1 [6] = '{0, 0, 0, 1, 1, 1};
    int exp4 [6] = '{0, 0, 1, 1, 0, 0};
    logic seen;

    reset = 1'b1; req = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    src = '0; dst = '0; dat = '0; red = '0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_i0_ack", 32'(i0_ack[k]), 32'd0);
      chk("rst_o0_req", 32'(o0_req[k]), 32'd0);
      chk("rst_o1_req", 32'(o1_req[k]), 32'd0);
      chk("rst_o_err",  32'(o_err[k]),  32'd0);
      chk("rst_cnt",    32'(err_cnt[k]), 32'd0);
      chk("rst_o0_dst", 32'(o0_dst[k]), 32'd0);
    end
    reset = 1'b0;
    tick();

    // dst 1..6 against dst > 3
    for (int i = 0; i < 6; i++) begin
      put(8'(i + 1), 8'(i), 4'h0);
      get(exp1[i], 8'(i + 1), 8'(i));
    end
    chk("sweep_o_err", 32'(o_err[0]), 32'd0);

    // o1 blocked: o0 traffic still flows, a further o1 message stalls
    put(8'd5, 8'h31, 4'h0);
    put(8'd2, 8'h32, 4'h0);
    get(0, 8'd2, 8'h32);
    src = 8'h50 ^ 8'h33; dst = 8'd6; dat = 8'h33; red = redf(8'h50 ^ 8'h33, 8'd6, 8'h33);
    req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | i0_ack[0];
    end
    chk("stall_i0_ack", 32'(seen), 32'd0);
    chk("stall_o1_req", 32'(o1_req[0]), 32'd1);
    req = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("stall_rst_o1_req", 32'(o1_req[0]), 32'd0);

    // corrupted red is acknowledged and dropped
    put(8'd2, 8'h11, 4'h1);
    tick(); tick(); tick();
    chk("bad_o0_req", 32'(o0_req[0]), 32'd0);
    chk("bad_o1_req", 32'(o1_req[0]), 32'd0);
    chk("bad_o_err",  32'(o_err[0]),  32'd1);
    chk("bad_cnt",    32'(err_cnt[0]), 32'd1);
    put(8'd4, 8'h12, 4'h0);
    get(1, 8'd4, 8'h12);
    chk("bad_after_cnt", 32'(err_cnt[0]), 32'd1);

    // range instance: only dst 3 and 4 go to o1
    sel = 1;
    for (int i = 0; i < 6; i++) begin
      put(8'(i + 1), 8'(8'h20 + i), 4'h0);
      get(exp4[i], 8'(i + 1), 8'(8'h20 + i));
    end
    chk("range_o_err", 32'(o_err[1]), 32'd0);
    sel = 0;

    // latency from first req cycle, then reset a cycle after o0_req rises
    src = 8'h50 ^ 8'h44; dst = 8'd2; dat = 8'h44; red = redf(8'h50 ^ 8'h44, 8'd2, 8'h44);
    req = 1'b1;
    tick();
    chk("lat_ack_c1", 32'(i0_ack[0]), 32'd0);
    tick();
    chk("lat_ack_c2", 32'(i0_ack[0]), 32'd1);
    chk("lat_req_c2", 32'(o0_req[0]), 32'd0);
    tick();
    chk("lat_req_c3", 32'(o0_req[0]), 32'd1);
    tick();
    reset = 1'b1;
    req = 1'b0;
    tick();
    chk("mid_rst_o0_req", 32'(o0_req[0]), 32'd0);
    chk("mid_rst_i0_ack", 32'(i0_ack[0]), 32'd0);
    chk("mid_rst_cnt",    32'(err_cnt[0]), 32'd0);
    chk("mid_rst_err",    32'(o_err[0]),  32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_slot0_empty", 32'(o0_req[0]), 32'd0);
    chk("post_rst_slot1_empty", 32'(o1_req[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
